// File: rtl/control_dispensador.sv
// rtl/control_dispensador.sv - vending machine credit, vend and change sequencer
//
// Tracks the inserted credit and runs the vend and change-return sequence. It also
// drives the 4-bit code for the 7-segment display: 4'b1010 idle, 4'b1011 dispensing,
// 4'b1100 returning change, 0-9 credit digit.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   coin1    in   one-cycle pulse, 1-unit coin
//   coin2    in   one-cycle pulse, 2-unit coin
//   bprodu   in   product button (level)
//   bcancel  in   cancel button (level)
//   dispense out  high while product is released (DISP_CYCLES cycles per vend)
//   coin_ret out  one-cycle pulse per 1-unit coin returned
//   coin_rej out  one-cycle pulse when an inserted coin is refused
//   credit   out  current credit, 0..MAX_CREDIT
//   numerin  out  display code
module control_dispensador #(
  parameter int PRICE       = 3,
  parameter int MAX_CREDIT  = 9,
  parameter int DISP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin1,
  input  logic       coin2,
  input  logic       bprodu,
  input  logic       bcancel,
  output logic       dispense,
  output logic       coin_ret,
  output logic       coin_rej,
  output logic [3:0] credit,
  output logic [3:0] numerin
);

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  localparam int         CNT_W     = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYCLES - 1);
  localparam logic [3:0] PRICE4    = 4'(PRICE);
  localparam logic [3:0] MAX4      = 4'(MAX_CREDIT);
  localparam logic [3:0] CODE_IDLE = 4'b1010;
  localparam logic [3:0] CODE_DISP = 4'b1011;
  localparam logic [3:0] CODE_CHG  = 4'b1100;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             phase_q, phase_n;   // CHANGE: 0 = pulse this cycle, 1 = gap cycle
  logic             prod_q, cancel_q;
  logic [3:0]       credit_n, numerin_n;
  logic             dispense_n, ret_n, rej_n;

  logic             prod_edge, cancel_edge, coin_any, fits;
  logic [3:0]       coin_val, coin_sum;

  assign prod_edge   = bprodu & ~prod_q;
  assign cancel_edge = bcancel & ~cancel_q;
  assign coin_any    = coin1 | coin2;
  assign coin_val    = (coin1 ? 4'd1 : 4'd0) + (coin2 ? 4'd2 : 4'd0);
  // Credit <= 9 and value <= 3, so the sum never wraps in 4 bits.
  assign coin_sum    = credit + coin_val;
  assign fits        = (coin_sum <= MAX4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      prod_q   <= 1'b0;
      cancel_q <= 1'b0;
      credit   <= 4'd0;
      dispense <= 1'b0;
      coin_ret <= 1'b0;
      coin_rej <= 1'b0;
      numerin  <= CODE_IDLE;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      phase_q  <= phase_n;
      prod_q   <= bprodu;
      cancel_q <= bcancel;
      credit   <= credit_n;
      dispense <= dispense_n;
      coin_ret <= ret_n;
      coin_rej <= rej_n;
      numerin  <= numerin_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    phase_n  = phase_q;
    credit_n = credit;
    ret_n    = 1'b0;
    rej_n    = 1'b0;

    case (state_q)
      IDLE: begin
        if (coin_any) begin
          if (fits) begin
            credit_n = coin_sum;
            state_n  = CREDIT;
          end else begin
            rej_n = 1'b1;
          end
        end
      end

      CREDIT: begin
        // A same-cycle coin is folded in whatever the buttons do.
        if (coin_any && fits)
          credit_n = coin_sum;
        else if (coin_any)
          rej_n = 1'b1;
        // Affordability uses the registered credit, not the coin-updated one.
        if (prod_edge && (credit >= PRICE4)) begin
          credit_n = credit_n - PRICE4;
          state_n  = DISPENSE;
          cnt_n    = '0;
        end else if (cancel_edge) begin
          state_n = CHANGE;
          phase_n = 1'b0;
        end
      end

      DISPENSE: begin
        rej_n = coin_any;
        if (cnt_q == DISP_LAST) begin
          state_n = (credit != 4'd0) ? CHANGE : IDLE;
          phase_n = 1'b0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      CHANGE: begin
        rej_n = coin_any;
        if (!phase_q) begin
          if (credit == 4'd0) begin
            state_n = IDLE;
          end else begin
            ret_n    = 1'b1;
            credit_n = credit - 4'd1;
            phase_n  = 1'b1;
          end
        end else begin
          phase_n = 1'b0;
          if (credit == 4'd0)
            state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    dispense_n = (state_n == DISPENSE);
    case (state_n)
      CREDIT:   numerin_n = credit_n;
      DISPENSE: numerin_n = CODE_DISP;
      CHANGE:   numerin_n = CODE_CHG;
      default:  numerin_n = CODE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_dispensador.sv
// tb/tb_control_dispensador.sv - self-checking bench for control_dispensador
module tb_control_dispensador;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin1 = 1'b0, coin2 = 1'b0, bprodu = 1'b0, bcancel = 1'b0;
  logic       dispense, coin_ret, coin_rej;
  logic [3:0] credit, numerin;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_ret = -100;
  int disp_cnt = 0, ret_cnt = 0, rej_cnt = 0;
  int exp_ret_q[$];   // expected credit seen with each coin_ret pulse

  control_dispensador #(.PRICE(3), .MAX_CREDIT(9), .DISP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .coin1(coin1), .coin2(coin2),
    .bprodu(bprodu), .bcancel(bcancel), .dispense(dispense),
    .coin_ret(coin_ret), .coin_rej(coin_rej), .credit(credit), .numerin(numerin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    disp_cnt += int'(dispense);
    rej_cnt  += int'(coin_rej);
    if (coin_ret) begin
      ret_cnt++;
      if (exp_ret_q.size() == 0) begin
        chk("unexpected_coin_ret", 1, 0);
      end else begin
        chk("ret_credit", 32'(credit), 32'(exp_ret_q.pop_front()));
        if (ret_cnt > 1) chk("ret_spacing", 32'(cyc - last_ret), 2);
      end
      last_ret = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    disp_cnt = 0; ret_cnt = 0; rej_cnt = 0;
  endtask

  task automatic coin(input logic c1, input logic c2);
    coin1 = c1; coin2 = c2;
    tick();
    coin1 = 1'b0; coin2 = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_numerin"}, 32'(numerin), 32'hA);
    chk({tag, "_credit"}, 32'(credit), 0);
    chk({tag, "_queue"}, 32'(exp_ret_q.size()), 0);
  endtask

  initial begin
    // Reset state
    run(2);
    chk("rst_dispense", 32'(dispense), 0);
    chk("rst_coin_ret", 32'(coin_ret), 0);
    chk("rst_coin_rej", 32'(coin_rej), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_numerin", 32'(numerin), 32'hA);
    rst_n = 1'b1;
    run(1);

    // Exact price
    coin(1'b0, 1'b1);
    chk("t1_credit2", 32'(credit), 2);
    chk("t1_numerin2", 32'(numerin), 2);
    tick();
    coin(1'b1, 1'b0);
    chk("t1_credit3", 32'(credit), 3);
    chk("t1_numerin3", 32'(numerin), 3);
    clr();
    bprodu = 1'b1;
    tick();
    chk("t1_disp_on", 32'(dispense), 1);
    chk("t1_numerin_disp", 32'(numerin), 32'hB);
    chk("t1_credit_after_vend", 32'(credit), 0);
    run(8);                  // button held: must not retrigger
    bprodu = 1'b0;
    chk("t1_disp_cycles", 32'(disp_cnt), 4);
    chk("t1_no_ret", 32'(ret_cnt), 0);
    idle_chk("t1_idle");

    // Overpay with change
    coin(1'b0, 1'b1); coin(1'b0, 1'b1); coin(1'b0, 1'b1);
    chk("t2_credit6", 32'(credit), 6);
    exp_ret_q.push_back(2); exp_ret_q.push_back(1); exp_ret_q.push_back(0);
    clr();
    bprodu = 1'b1; tick(); bprodu = 1'b0;
    run(20);
    chk("t2_disp_cycles", 32'(disp_cnt), 4);
    chk("t2_ret_count", 32'(ret_cnt), 3);
    idle_chk("t2_idle");

    // Insufficient credit, then cancel
    coin(1'b1, 1'b0);
    chk("t3_credit1", 32'(credit), 1);
    clr();
    bprodu = 1'b1; tick(); bprodu = 1'b0;
    run(3);
    chk("t3_no_disp", 32'(disp_cnt), 0);
    chk("t3_numerin1", 32'(numerin), 1);
    exp_ret_q.push_back(0);
    bcancel = 1'b1; tick(); bcancel = 1'b0;
    chk("t3_numerin_chg", 32'(numerin), 32'hC);
    run(10);
    chk("t3_ret_count", 32'(ret_cnt), 1);
    idle_chk("t3_idle");

    // Overflow refusal
    for (int i = 0; i < 4; i++) coin(1'b0, 1'b1);
    chk("t4_credit8", 32'(credit), 8);
    clr();
    coin(1'b0, 1'b1);
    chk("t4_rej_pulse", 32'(coin_rej), 1);
    chk("t4_credit_kept", 32'(credit), 8);
    tick();
    chk("t4_rej_low", 32'(coin_rej), 0);
    coin(1'b1, 1'b0);
    chk("t4_credit9", 32'(credit), 9);
    chk("t4_rej_total", 32'(rej_cnt), 1);
    for (int v = 8; v >= 0; v--) exp_ret_q.push_back(v);
    clr();
    bcancel = 1'b1; tick(); bcancel = 1'b0;
    run(25);
    chk("t4_ret_count", 32'(ret_cnt), 9);
    idle_chk("t4_idle");

    // Simultaneous coins, then vend with same-cycle coin
    coin(1'b1, 1'b1);
    chk("t5_credit3", 32'(credit), 3);
    exp_ret_q.push_back(0);
    clr();
    bprodu = 1'b1; coin1 = 1'b1;
    tick();
    bprodu = 1'b0; coin1 = 1'b0;
    chk("t5_disp_on", 32'(dispense), 1);
    chk("t5_credit_left", 32'(credit), 1);
    run(15);
    chk("t5_disp_cycles", 32'(disp_cnt), 4);
    chk("t5_ret_count", 32'(ret_cnt), 1);
    idle_chk("t5_idle");

    // Vend and cancel together: vend wins
    coin(1'b1, 1'b1);
    clr();
    bprodu = 1'b1; bcancel = 1'b1;
    tick();
    bprodu = 1'b0; bcancel = 1'b0;
    chk("t6_vend_wins", 32'(dispense), 1);
    run(10);
    chk("t6_disp_cycles", 32'(disp_cnt), 4);
    chk("t6_no_ret", 32'(ret_cnt), 0);
    idle_chk("t6_idle");

    // Reset in the middle of CHANGE
    coin(1'b0, 1'b1); coin(1'b0, 1'b1); coin(1'b1, 1'b0);
    chk("t7_credit5", 32'(credit), 5);
    exp_ret_q.push_back(4); exp_ret_q.push_back(3);
    clr();
    bcancel = 1'b1; tick(); bcancel = 1'b0;
    for (int i = 0; i < 20 && ret_cnt < 2; i++) tick();
    chk("t7_two_rets", 32'(ret_cnt), 2);
    rst_n = 1'b0;
    #1;
    chk("t7_async_dispense", 32'(dispense), 0);
    chk("t7_async_coin_ret", 32'(coin_ret), 0);
    chk("t7_async_coin_rej", 32'(coin_rej), 0);
    chk("t7_async_credit", 32'(credit), 0);
    chk("t7_async_numerin", 32'(numerin), 32'hA);
    run(2);
    rst_n = 1'b1;
    run(12);
    chk("t7_no_more_rets", 32'(ret_cnt), 2);
    idle_chk("t7_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_dispensador.md
Name: control_dispensador

Overview:
- Sequencing controller for the vending machine's product-output display path.
- Accepts coin pulses and tracks credit.
- Arbitrates the product-request and cancel buttons, times the dispense pulse and pays back change one unit at a time.
- Drives the 4-bit display code consumed by the 7-segment decoder. Codes: 4'b1010 idle, 4'b1011 dispensing, 4'b1100 returning change, 0-9 credit digit.

Parameters:
- PRICE, 3, product price in credit units (1..MAX_CREDIT).
- MAX_CREDIT, 9, credit ceiling; must be ≤ 9 so credit fits one display digit.
- DISP_CYCLES, 4, number of clock cycles the dispense output stays high per vend.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- coin1  input  1  one-cycle pulse, 1-unit coin inserted.
- coin2  input  1  one-cycle pulse, 2-unit coin inserted.
- bprodu  input  1  product button, level, synchronous to clk.
- bcancel  input  1  cancel button, level, synchronous to clk.
- dispense  output  1  high while the product is being released.
- coin_ret  output  1  one-cycle pulse per 1-unit coin returned.
- coin_rej  output  1  one-cycle pulse when an inserted coin is refused.
- credit  output  4  current credit, 0..MAX_CREDIT.
- numerin  output  4  display code.

Behaviour:
- Reset and output timing:
  - Asynchronous reset to state IDLE; credit = 0; dispense, coin_ret, coin_rej = 0; numerin = 4'b1010.
  - All outputs are registered and change one cycle after the causing input edge.
- Buttons: rising-edge detected internally with one register each. Holding a button produces one event only.
- Coin value: coin1 = 1, coin2 = 2, both in the same cycle = 3.
- Coin acceptance:
  - Accepted only in IDLE or CREDIT, and only if credit + value ≤ MAX_CREDIT.
  - Otherwise coin_rej pulses for one cycle and credit is unchanged; this includes all coins arriving in DISPENSE or CHANGE.
- States:
  - IDLE: credit = 0, numerin = 4'b1010. An accepted coin moves to CREDIT.
  - CREDIT: numerin = credit value.
    - bprodu edge with credit ≥ PRICE (registered credit, before any same-cycle coin) → credit -= PRICE, go to DISPENSE.
    - bprodu edge with credit < PRICE → ignored; remain in CREDIT.
    - bcancel edge → go to CHANGE.
    - bprodu edge and bcancel edge in the same cycle → bprodu has priority if the vend is affordable; otherwise the cancel is taken.
  - DISPENSE: dispense = 1 for exactly DISP_CYCLES cycles, numerin = 4'b1011. Buttons are ignored. At the end: credit > 0 → CHANGE, credit = 0 → IDLE.
  - CHANGE: numerin = 4'b1100.
    - coin_ret pattern is high 1 cycle, low 1 cycle, repeating; each high cycle decrements credit by 1.
    - After the pulse that brings credit to 0, return to IDLE on the next cycle.
    - Buttons are ignored.
- Same-cycle coin and vend in CREDIT:
  - The coin is accepted if registered credit + value ≤ MAX_CREDIT.
  - credit_next = credit − PRICE + value.
  - The FSM still enters DISPENSE, and the remaining credit is returned in CHANGE afterwards.
- Arithmetic: credit is a 4-bit unsigned value. It never underflows (vend only when ≥ PRICE) and never exceeds MAX_CREDIT (coins are refused instead).
- Reset mid-operation: reset in DISPENSE or CHANGE aborts immediately. Pending change is lost; outputs go to their reset values.
- No combinational path from any input to any output.

Test Plan:
- Exact price: reset; coin2, then coin1 two cycles later → credit 3, numerin 3. bprodu edge → dispense high 4 cycles, numerin 4'b1011, then IDLE, numerin 4'b1010, no coin_ret.
- Overpay with change: three coin2 pulses (credit 6); bprodu → dispense 4 cycles, then CHANGE. Exactly 3 coin_ret pulses spaced 2 cycles apart, credit counts 2,1,0, then IDLE.
- Insufficient credit, then cancel: coin1 (credit 1); bprodu → no dispense, numerin stays 1. bcancel → one coin_ret pulse, then IDLE.
- Overflow refusal: credit 8; coin2 → coin_rej one-cycle pulse, credit stays 8. coin1 → accepted, credit 9.
- Simultaneous events:
  - coin1 and coin2 in the same cycle → credit +3.
  - credit 3, bprodu and coin1 in the same cycle → dispense, then 1 coin_ret.
  - bprodu and bcancel together with credit 3 → vend wins.
- Reset mid-CHANGE: credit 5, cancel, assert rst_n = 0 after the second coin_ret → all outputs immediately 0, numerin 4'b1010; no further coin_ret after release.
